// File: rtl/add_seq_ctrl_pkg.sv
// Shared constants and FSM state type for the multi-word addition sequencer.
package add_seq_pkg;

  localparam int unsigned ADD_WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/add_seq_ctrl_if.sv
// Handshake/operand bundle for add_seq_ctrl; the sub line exists only with ADD_SEQ_SUB_EN.
interface add_seq_ctrl_if
  import add_seq_pkg::*;
#(
  parameter int unsigned WORDS = 2
) ();

  localparam int unsigned W = ADD_WORD_W * WORDS;

  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         cin;
`ifdef ADD_SEQ_SUB_EN
  logic         sub;
`endif
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;
  logic [2:0]   word_idx;

  modport master (
    output start, op_a, op_b, cin,
`ifdef ADD_SEQ_SUB_EN
    output sub,
`endif
    input  ready, busy, done, result, cout, ovf, word_idx
  );

  modport slave (
    input  start, op_a, op_b, cin,
`ifdef ADD_SEQ_SUB_EN
    input  sub,
`endif
    output ready, busy, done, result, cout, ovf, word_idx
  );

endinterface

// File: rtl/add_seq_ctrl_adder32.sv
// Shared 32-bit ripple adder slice used by the sequencer, one word per cycle.
module adder32 (
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  always_comb begin
    {cout, sum} = {1'b0, op1} + {1'b0, op2} + {32'd0, cin};
  end

endmodule

// File: rtl/add_seq_ctrl.sv
// Multi-word add sequencer: one adder32 slice per cycle, LS word first, carry kept in a register.
// Optional subtract mode (sub port) is enabled with `define ADD_SEQ_SUB_EN.
module add_seq_ctrl
  import add_seq_pkg::*;
#(
  parameter int unsigned WORDS = 2
) (
  input  logic         clk,
  input  logic         resetn,
  add_seq_ctrl_if.slave bus
);

  localparam int unsigned W = ADD_WORD_W * WORDS;

  state_t         state_q, state_d;
  logic [2:0]     idx_q;
  logic [W-1:0]   a_q, b_q, res_q;
  logic           carry_q, ovf_q;
  logic           last_word, sub_l;

  logic [ADD_WORD_W-1:0] add_op1, add_op2, add_sum;
  logic                  add_cout;

`ifdef ADD_SEQ_SUB_EN
  assign sub_l = bus.sub;
`else
  assign sub_l = 1'b0;
`endif

  assign last_word = (idx_q == 3'(WORDS - 1));

  always_comb begin
    add_op1 = a_q[int'(idx_q) * ADD_WORD_W +: ADD_WORD_W];
    add_op2 = b_q[int'(idx_q) * ADD_WORD_W +: ADD_WORD_W];
  end

  adder32 u_adder (
    .op1  (add_op1),
    .op2  (add_op2),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_RUN;
      ST_RUN:  if (last_word) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // b is stored already inverted in subtract mode, so ovf sees the effective MSB
  always_ff @(posedge clk) begin
    if (!resetn) begin
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            a_q     <= bus.op_a;
            b_q     <= sub_l ? ~bus.op_b : bus.op_b;
            carry_q <= sub_l ? 1'b1 : bus.cin;
            idx_q   <= '0;
          end
        end
        ST_RUN: begin
          res_q[int'(idx_q) * ADD_WORD_W +: ADD_WORD_W] <= add_sum;
          carry_q <= add_cout;
          if (last_word)
            ovf_q <= (a_q[W-1] == b_q[W-1]) && (add_sum[ADD_WORD_W-1] != a_q[W-1]);
          else
            idx_q <= idx_q + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.ready    = (state_q == ST_IDLE);
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.done     = (state_q == ST_DONE);
  assign bus.result   = res_q;
  assign bus.cout     = carry_q;
  assign bus.ovf      = ovf_q;
  assign bus.word_idx = idx_q;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Randomized self-checking bench for add_seq_ctrl (WORDS=2 and WORDS=1 instances).
module tb_add_seq_ctrl;
  import add_seq_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  add_seq_ctrl_if #(.WORDS(2)) bus0 ();
  add_seq_ctrl_if #(.WORDS(1)) bus1 ();

  add_seq_ctrl #(.WORDS(2)) u0 (.clk(clk), .resetn(resetn), .bus(bus0.slave));
  add_seq_ctrl #(.WORDS(1)) u1 (.clk(clk), .resetn(resetn), .bus(bus1.slave));

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // WORDS=2 operation against a plain arithmetic model
  task automatic run0(input string tag, input logic [63:0] a, input logic [63:0] b,
                      input logic ci, input logic sb);
    logic [63:0] be;
    logic        c0;
    logic [64:0] full;
    logic        ov;
    int          cyc;
    bit          seen;
    be   = sb ? ~b : b;
    c0   = sb ? 1'b1 : ci;
    full = {1'b0, a} + {1'b0, be} + {64'd0, c0};
    ov   = (a[63] == be[63]) && (full[63] != a[63]);
    check_val({tag, ".ready"}, bus0.ready, 1);
    bus0.start = 1'b1; bus0.op_a = a; bus0.op_b = b; bus0.cin = ci;
`ifdef ADD_SEQ_SUB_EN
    bus0.sub = sb;
`endif
    step();
    bus0.start = 1'b0;
    bus0.op_a = {$urandom, $urandom}; bus0.op_b = {$urandom, $urandom}; bus0.cin = 1'($urandom);
    cyc = 1; seen = 0;
    while (!seen && cyc < 20) begin
      if (bus0.done) seen = 1;
      else begin
        check_val({tag, ".widx"}, bus0.word_idx, cyc - 1);
        check_val({tag, ".busy"}, bus0.busy, 1);
        step();
        cyc++;
      end
    end
    check_val({tag, ".done_cyc"}, cyc, 3);
    check_val({tag, ".result"}, bus0.result, full[63:0]);
    check_val({tag, ".cout"}, bus0.cout, full[64]);
    check_val({tag, ".ovf"}, bus0.ovf, ov);
    step();
    check_val({tag, ".ready_after"}, bus0.ready, 1);
    check_val({tag, ".hold"}, bus0.result, full[63:0]);
  endtask

  task automatic run1(input string tag, input logic [31:0] a, input logic [31:0] b, input logic ci);
    logic [32:0] full;
    logic        ov;
    int          cyc;
    full = {1'b0, a} + {1'b0, b} + {32'd0, ci};
    ov   = (a[31] == b[31]) && (full[31] != a[31]);
    bus1.start = 1'b1; bus1.op_a = a; bus1.op_b = b; bus1.cin = ci;
`ifdef ADD_SEQ_SUB_EN
    bus1.sub = 1'b0;
`endif
    step();
    bus1.start = 1'b0;
    cyc = 1;
    while (!bus1.done && cyc < 20) begin
      step();
      cyc++;
    end
    check_val({tag, ".done_cyc"}, cyc, 2);
    check_val({tag, ".result"}, bus1.result, full[31:0]);
    check_val({tag, ".cout"}, bus1.cout, full[32]);
    check_val({tag, ".ovf"}, bus1.ovf, ov);
    step();
  endtask

  initial begin
    int       dcyc[$];
    bit       seen_done;
    logic     sb;
    bus0.start = 0; bus0.op_a = '0; bus0.op_b = '0; bus0.cin = 0;
    bus1.start = 0; bus1.op_a = '0; bus1.op_b = '0; bus1.cin = 0;
`ifdef ADD_SEQ_SUB_EN
    bus0.sub = 0; bus1.sub = 0;
`endif
    resetn = 1'b0;
    step(); step();
    check_val("rst.ready", bus0.ready, 1);
    check_val("rst.busy", bus0.busy, 0);
    check_val("rst.done", bus0.done, 0);
    check_val("rst.result", bus0.result, 0);
    check_val("rst.cout", bus0.cout, 0);
    check_val("rst.ovf", bus0.ovf, 0);
    check_val("rst.widx", bus0.word_idx, 0);
    check_val("rst1.ready", bus1.ready, 1);
    resetn = 1'b1;
    step();

    run0("t1", 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    check_val("t1.exp", bus0.result, 64'h0000_0001_0000_0000);
    run0("t2", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    check_val("t2.exp_cout", bus0.cout, 1);
    run0("t3", 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0);
    check_val("t3.exp_ovf", bus0.ovf, 1);

    for (int i = 0; i < 20; i++) begin
`ifdef ADD_SEQ_SUB_EN
      sb = 1'($urandom);
`else
      sb = 1'b0;
`endif
      run0("rnd", {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), sb);
    end

`ifdef ADD_SEQ_SUB_EN
    run0("t5a", 64'd5, 64'd7, 1'b0, 1'b1);
    check_val("t5a.exp", bus0.result, 64'hFFFF_FFFF_FFFF_FFFE);
    run0("t5b", 64'd7, 64'd5, 1'b1, 1'b1);
    check_val("t5b.exp", bus0.result, 64'd2);
    check_val("t5b.cout", bus0.cout, 1);
`endif

    // extra start pulses during RUN are ignored; then reset right after done
    bus0.start = 1; bus0.op_a = 64'd5; bus0.op_b = 64'd7; bus0.cin = 0;
    step();
    bus0.op_a = 64'd100; bus0.op_b = 64'd200;
    step();
    step();
    bus0.start = 0;
    check_val("t4.done", bus0.done, 1);
    check_val("t4.result", bus0.result, 64'd12);
    step();
    resetn = 0;
    step();
    resetn = 1;
    check_val("t4.rst_ready", bus0.ready, 1);
    check_val("t4.rst_result", bus0.result, 0);

    // reset mid-RUN after word 0 was written
    bus0.start = 1; bus0.op_a = '1; bus0.op_b = 64'h1234_5678_9ABC_DEF0; bus0.cin = 1;
    step();
    bus0.start = 0;
    step();
    resetn = 0;
    step();
    resetn = 1;
    check_val("t4m.ready", bus0.ready, 1);
    check_val("t4m.busy", bus0.busy, 0);
    check_val("t4m.result", bus0.result, 0);
    check_val("t4m.cout", bus0.cout, 0);
    check_val("t4m.ovf", bus0.ovf, 0);
    check_val("t4m.widx", bus0.word_idx, 0);
    seen_done = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus0.done) seen_done = 1;
      step();
    end
    check_val("t4m.no_done", seen_done, 0);

    // start held high: accepted each time IDLE is re-entered
    bus0.start = 1; bus0.op_a = 64'd1; bus0.op_b = 64'd2; bus0.cin = 0;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (bus0.done) dcyc.push_back(c);
    end
    bus0.start = 0;
    step(); step(); step(); step();
    check_val("hold.n_done", dcyc.size(), 2);
    if (dcyc.size() >= 2) begin
      check_val("hold.first", dcyc[0], 3);
      check_val("hold.gap", dcyc[1] - dcyc[0], 4);
    end
    check_val("hold.result", bus0.result, 64'd3);

    run1("t6", 32'hFFFF_FFFF, 32'h1, 1'b1);
    check_val("t6.exp", bus1.result, 32'h1);
    for (int i = 0; i < 6; i++)
      run1("rnd1", $urandom, $urandom, 1'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
